// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and uart_lite-side handshake bundle for uart_tx_arbiter.
// slave = arbiter view, master = environment view (requesters plus the uart_lite TX port).
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned DATA_BITS = 8
);
  logic [N_REQ-1:0]           req_vld;
  logic [N_REQ*DATA_BITS-1:0] req_data;
  logic [N_REQ-1:0]           req_last;
  logic [N_REQ-1:0]           req_rdy;
  logic                       uart_tx_rdy;
  logic                       uart_tx_vld;
  logic [DATA_BITS-1:0]       uart_tx_data;

  modport slave (
    input  req_vld,
    input  req_data,
    input  req_last,
    input  uart_tx_rdy,
    output req_rdy,
    output uart_tx_vld,
    output uart_tx_data
  );

  modport master (
    output req_vld,
    output req_data,
    output req_last,
    output uart_tx_rdy,
    input  req_rdy,
    input  uart_tx_vld,
    input  uart_tx_data
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_lite TX port between N_REQ requesters.
// Round-robin at packet granularity; the grant is held until the byte flagged req_last
// (or the MAX_PKT_BYTES-th byte) has been fully serialized by uart_lite.
// Optional macro ARB_TIMEOUT_EN: a grant whose owner withholds req_vld for TIMEOUT_CLKS
// cycles in GRANT is released with a one-cycle timeout_err pulse.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned MAX_PKT_BYTES = 0,
  parameter int unsigned TIMEOUT_CLKS  = 1000000
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_tx_arbiter_if.slave         bus,
  output logic [$clog2(N_REQ)-1:0] grant,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned IdxW       = $clog2(N_REQ);
  localparam int unsigned CntW       = (MAX_PKT_BYTES == 0) ? 1 : $clog2(MAX_PKT_BYTES + 1);
  localparam int unsigned MaxLastIdx = (MAX_PKT_BYTES == 0) ? 0 : MAX_PKT_BYTES - 1;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWaitBusy,
    StWaitDone
  } state_e;

  state_e               state_q, state_d;
  logic [IdxW-1:0]      grant_q, grant_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 tx_vld_q, tx_vld_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;

  logic [IdxW-1:0]      winner;
  logic                 win_found;
  logic                 sel_vld;
  logic                 sel_last;
  logic [DATA_BITS-1:0] sel_data;
  logic                 hs;
  logic                 max_hit;
  logic                 stall_hit;
  logic [N_REQ-1:0]     req_rdy;

  // Round-robin search: first active requester strictly after ptr, wrapping to ptr itself.
  always_comb begin
    logic [IdxW-1:0] idx;
    winner    = ptr_q;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IdxW'((32'(ptr_q) + k) % N_REQ);
      if (!win_found && bus.req_vld[idx]) begin
        win_found = 1'b1;
        winner    = idx;
      end
    end
  end

  // Select the granted requester's byte.
  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_q == IdxW'(i)) begin
        sel_data = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end

  assign sel_vld  = bus.req_vld[grant_q];
  assign sel_last = bus.req_last[grant_q];
  assign hs       = (state_q == StGrant) && sel_vld && bus.uart_tx_rdy;
  assign max_hit  = (MAX_PKT_BYTES != 0) && (cnt_q == CntW'(MaxLastIdx));

  // Byte accept strobe goes only to the owner, only in the handshake cycle.
  always_comb begin
    req_rdy = '0;
    if (hs) begin
      req_rdy[grant_q] = 1'b1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT_CLKS + 1);

  logic [StallW-1:0] stall_q, stall_d;

  // Fires during the TIMEOUT_CLKS-th consecutive-or-not stall cycle of the current byte slot.
  assign stall_hit   = (state_q == StGrant) && !sel_vld &&
                       (stall_q == StallW'(TIMEOUT_CLKS - 1));
  assign timeout_err = stall_hit;

  // Stall counter: cleared outside GRANT (covers GRANT entry) and on handshake.
  always_comb begin
    stall_d = stall_q;
    if (state_q != StGrant || hs) begin
      stall_d = '0;
    end else if (!sel_vld) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CLKS;
  assign stall_hit          = 1'b0;
  assign timeout_err        = 1'b0;
`endif

  // Next-state and datapath updates for the packet sequencer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          grant_d = winner;
          cnt_d   = '0;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (stall_hit) begin
          // Truncate the packet and let the next requester in.
          ptr_d   = grant_q;
          state_d = StIdle;
        end else if (hs) begin
          tx_data_d = sel_data;
          tx_vld_d  = 1'b1;
          last_d    = sel_last || max_hit;
          cnt_d     = cnt_q + 1'b1;
          state_d   = StWaitBusy;
        end
      end
      StWaitBusy: begin
        // uart_lite drops tx_rdy once it has taken the byte.
        if (!bus.uart_tx_rdy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (bus.uart_tx_rdy) begin
          if (last_q) begin
            ptr_d   = grant_q;
            state_d = StIdle;
          end else begin
            state_d = StGrant;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      ptr_q     <= IdxW'(N_REQ - 1);
      cnt_q     <= '0;
      last_q    <= 1'b0;
      tx_vld_q  <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      tx_vld_q  <= tx_vld_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.req_rdy      = req_rdy;
  assign bus.uart_tx_vld  = tx_vld_q;
  assign bus.uart_tx_data = tx_data_q;
  assign grant            = grant_q;
  assign busy             = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter.
// dut_a uses default parameters; dut_b uses MAX_PKT_BYTES=3 and TIMEOUT_CLKS=20.
// Each DUT talks to a uart_lite stub that holds tx_rdy low for 3 cycles per byte.
module tb_uart_tx_arbiter;
  localparam int unsigned NReq = 4;
  localparam int unsigned Db   = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(NReq), .DATA_BITS(Db)) bus_a ();
  uart_tx_arbiter_if #(.N_REQ(NReq), .DATA_BITS(Db)) bus_b ();

  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b, to_a, to_b;

  uart_tx_arbiter #(
    .N_REQ(NReq), .DATA_BITS(Db), .MAX_PKT_BYTES(0), .TIMEOUT_CLKS(1000000)
  ) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a), .grant(grant_a), .busy(busy_a), .timeout_err(to_a)
  );

  uart_tx_arbiter #(
    .N_REQ(NReq), .DATA_BITS(Db), .MAX_PKT_BYTES(3), .TIMEOUT_CLKS(20)
  ) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b), .grant(grant_b), .busy(busy_b), .timeout_err(to_b)
  );

  // uart_lite stubs: take the byte on vld&&rdy, stay busy for 3 cycles.
  logic [1:0] stub_cnt_a, stub_cnt_b;
  always @(posedge clk) begin
    if (reset) begin
      bus_a.uart_tx_rdy <= 1'b1;
      stub_cnt_a        <= 2'd0;
    end else if (bus_a.uart_tx_rdy && bus_a.uart_tx_vld) begin
      bus_a.uart_tx_rdy <= 1'b0;
      stub_cnt_a        <= 2'd3;
    end else if (!bus_a.uart_tx_rdy) begin
      if (stub_cnt_a == 2'd1) bus_a.uart_tx_rdy <= 1'b1;
      stub_cnt_a <= stub_cnt_a - 2'd1;
    end
  end
  always @(posedge clk) begin
    if (reset) begin
      bus_b.uart_tx_rdy <= 1'b1;
      stub_cnt_b        <= 2'd0;
    end else if (bus_b.uart_tx_rdy && bus_b.uart_tx_vld) begin
      bus_b.uart_tx_rdy <= 1'b0;
      stub_cnt_b        <= 2'd3;
    end else if (!bus_b.uart_tx_rdy) begin
      if (stub_cnt_b == 2'd1) bus_b.uart_tx_rdy <= 1'b1;
      stub_cnt_b <= stub_cnt_b - 2'd1;
    end
  end

  // Requester models: per DUT, per requester byte queues of {last, data}.
  logic [8:0]      mem     [2][NReq][16];
  int              wr_n    [2][NReq];
  int              rd_n    [2][NReq];
  bit              paused  [2][NReq];
  logic [NReq-1:0] hs_rec  [2];

  // Monitor logs.
  int         ord      [2][64];
  logic [7:0] txd      [2][64];
  int         txc      [2][64];
  int         n_ord    [2];
  int         n_tx     [2];
  int         rdy_cnt  [2][NReq];
  int         viol     [2];
  int         rise_cyc [2];
  int         fall_cyc [2];
  int         to_cnt   [2];
  int         to_cyc   [2];
  logic       prev_tx  [2];
  logic       prev_urdy[2];
  logic       prev_busy[2];
  int         cyc;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      n_ord[d] = 0; n_tx[d] = 0; viol[d] = 0; rise_cyc[d] = 0; fall_cyc[d] = 0;
      to_cnt[d] = 0; to_cyc[d] = 0; hs_rec[d] = '0;
      for (int r = 0; r < NReq; r++) rdy_cnt[d][r] = 0;
    end
  endtask

  task automatic clear_all();
    clear_mon();
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < NReq; r++) begin
        wr_n[d][r] = 0; rd_n[d][r] = 0; paused[d][r] = 1'b0;
      end
    end
  endtask

  task automatic push(input int d, input int r, input logic [7:0] b, input logic l);
    if (wr_n[d][r] < 16) begin
      mem[d][r][wr_n[d][r]] = {l, b};
      wr_n[d][r]++;
    end
  endtask

  task automatic drive_inputs();
    logic [NReq-1:0]    v [2];
    logic [NReq-1:0]    l [2];
    logic [NReq*Db-1:0] dt[2];
    logic [8:0]         e;
    for (int d = 0; d < 2; d++) begin
      v[d] = '0; l[d] = '0; dt[d] = '0;
      for (int r = 0; r < NReq; r++) begin
        if (!paused[d][r] && rd_n[d][r] < wr_n[d][r]) begin
          e = mem[d][r][rd_n[d][r]];
          v[d][r] = 1'b1;
          l[d][r] = e[8];
          dt[d][r*Db +: Db] = e[7:0];
        end
      end
    end
    bus_a.req_vld = v[0]; bus_a.req_last = l[0]; bus_a.req_data = dt[0];
    bus_b.req_vld = v[1]; bus_b.req_last = l[1]; bus_b.req_data = dt[1];
  endtask

  task automatic mon_one(input int d, input logic [NReq-1:0] vld, input logic [NReq-1:0] rdy,
                         input logic tx_vld, input logic [7:0] tx_data, input logic urdy,
                         input logic [1:0] g, input logic bsy, input logic to);
    logic [NReq-1:0] hs;
    logic [NReq-1:0] exp_oh;
    hs = vld & rdy;
    exp_oh = '0;
    exp_oh[g] = 1'b1;
    if (reset) begin
      hs_rec[d] = '0;
    end else begin
      if (rdy != '0) begin
        if (rdy != exp_oh || !bsy || hs != rdy) viol[d]++;
        for (int r = 0; r < NReq; r++) begin
          if (hs[r]) begin
            rdy_cnt[d][r]++;
            if (n_ord[d] < 64) begin ord[d][n_ord[d]] = r; n_ord[d]++; end
          end
        end
      end
      hs_rec[d] = hs;
      if (tx_vld) begin
        if (prev_tx[d]) viol[d]++;
        if (n_tx[d] < 64) begin
          txd[d][n_tx[d]] = tx_data; txc[d][n_tx[d]] = cyc; n_tx[d]++;
        end
      end
      if (urdy && !prev_urdy[d]) rise_cyc[d] = cyc;
      if (!bsy && prev_busy[d]) fall_cyc[d] = cyc;
      if (to) begin to_cnt[d]++; to_cyc[d] = cyc; end
    end
    prev_tx[d] = tx_vld; prev_urdy[d] = urdy; prev_busy[d] = bsy;
  endtask

  // One clock: pop accepted bytes after the edge, drive, then sample at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NReq; r++)
        if (hs_rec[d][r]) rd_n[d][r]++;
    drive_inputs();
    @(negedge clk);
    cyc++;
    mon_one(0, bus_a.req_vld, bus_a.req_rdy, bus_a.uart_tx_vld, bus_a.uart_tx_data,
            bus_a.uart_tx_rdy, grant_a, busy_a, to_a);
    mon_one(1, bus_b.req_vld, bus_b.req_rdy, bus_b.uart_tx_vld, bus_b.uart_tx_data,
            bus_b.uart_tx_rdy, grant_b, busy_b, to_b);
  endtask

  task automatic start_test();
    reset = 1'b1;
    clear_all();
    tick();
    tick();
    reset = 1'b0;
  endtask

  int         exp_ord2 [8] = '{0, 0, 2, 2, 3, 3, 0, 0};
  logic [7:0] exp_dat2 [8] = '{8'h01, 8'h02, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
  int         exp_ord4 [7] = '{0, 0, 0, 1, 1, 0, 0};
  logic [7:0] exp_dat4 [7] = '{8'hA1, 8'hA2, 8'hA3, 8'hB1, 8'hB2, 8'hA4, 8'hA5};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    for (int d = 0; d < 2; d++) begin prev_tx[d] = 0; prev_urdy[d] = 0; prev_busy[d] = 0; end
    reset = 1'b1;
    clear_all();
    drive_inputs();
    repeat (3) tick();

    // Reset values.
    check_eq("rst_req_rdy", 32'(bus_a.req_rdy), 32'd0);
    check_eq("rst_tx_vld", 32'(bus_a.uart_tx_vld), 32'd0);
    check_eq("rst_tx_data", 32'(bus_a.uart_tx_data), 32'd0);
    check_eq("rst_grant", 32'(grant_a), 32'd0);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_timeout", 32'(to_a), 32'd0);
    reset = 1'b0;

    // Single requester 1 sends 0x55, 0xAA(last).
    start_test();
    push(0, 1, 8'h55, 1'b0);
    push(0, 1, 8'hAA, 1'b1);
    for (int i = 0; i < 200 && !(n_tx[0] == 2 && !busy_a); i++) tick();
    check_eq("t1_n_tx", 32'(n_tx[0]), 32'd2);
    check_eq("t1_byte0", 32'(txd[0][0]), 32'h55);
    check_eq("t1_byte1", 32'(txd[0][1]), 32'hAA);
    check_eq("t1_rdy1_cnt", 32'(rdy_cnt[0][1]), 32'd2);
    check_eq("t1_byte_gap", 32'(txc[0][1] - txc[0][0]), 32'd6);
    check_eq("t1_busy_fall", 32'(fall_cyc[0] - rise_cyc[0]), 32'd1);
    check_eq("t1_viol", 32'(viol[0]), 32'd0);

    // Reqs 0, 2, 3 simultaneous 2-byte packets; req 0 has a second packet queued.
    start_test();
    push(0, 0, 8'h01, 1'b0); push(0, 0, 8'h02, 1'b1);
    push(0, 0, 8'h03, 1'b0); push(0, 0, 8'h04, 1'b1);
    push(0, 2, 8'h21, 1'b0); push(0, 2, 8'h22, 1'b1);
    push(0, 3, 8'h31, 1'b0); push(0, 3, 8'h32, 1'b1);
    for (int i = 0; i < 600 && !(n_tx[0] == 8 && !busy_a); i++) tick();
    check_eq("t2_n_ord", 32'(n_ord[0]), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("t2_ord%0d", k), 32'(ord[0][k]), 32'(exp_ord2[k]));
      check_eq($sformatf("t2_dat%0d", k), 32'(txd[0][k]), 32'(exp_dat2[k]));
    end
    check_eq("t2_viol", 32'(viol[0]), 32'd0);

    // Req 1 stalls mid-packet for 50 cycles while req 2 waits.
    start_test();
    push(0, 1, 8'h11, 1'b0); push(0, 1, 8'h12, 1'b1);
    push(0, 2, 8'h21, 1'b1);
    for (int i = 0; i < 100 && rdy_cnt[0][1] == 0; i++) tick();
    paused[0][1] = 1'b1;
    repeat (50) tick();
    check_eq("t3_no_rdy2", 32'(rdy_cnt[0][2]), 32'd0);
    check_eq("t3_grant_held", 32'(grant_a), 32'd1);
    check_eq("t3_busy_held", 32'(busy_a), 32'd1);
    paused[0][1] = 1'b0;
    for (int i = 0; i < 300 && !(n_tx[0] == 3 && !busy_a); i++) tick();
    check_eq("t3_ord0", 32'(ord[0][0]), 32'd1);
    check_eq("t3_ord1", 32'(ord[0][1]), 32'd1);
    check_eq("t3_ord2", 32'(ord[0][2]), 32'd2);
    check_eq("t3_dat2", 32'(txd[0][2]), 32'h21);
    check_eq("t3_viol", 32'(viol[0]), 32'd0);

    // MAX_PKT_BYTES=3: req 0 sends 5 bytes without last, req 1 pending.
    start_test();
    push(1, 0, 8'hA1, 1'b0); push(1, 0, 8'hA2, 1'b0); push(1, 0, 8'hA3, 1'b0);
    push(1, 0, 8'hA4, 1'b0); push(1, 0, 8'hA5, 1'b0);
    push(1, 1, 8'hB1, 1'b0); push(1, 1, 8'hB2, 1'b1);
    for (int i = 0; i < 600 && n_ord[1] < 7; i++) tick();
    repeat (10) tick();
    check_eq("t4_n_ord", 32'(n_ord[1]), 32'd7);
    for (int k = 0; k < 7; k++) begin
      check_eq($sformatf("t4_ord%0d", k), 32'(ord[1][k]), 32'(exp_ord4[k]));
      check_eq($sformatf("t4_dat%0d", k), 32'(txd[1][k]), 32'(exp_dat4[k]));
    end
    check_eq("t4_grant_kept", 32'(grant_b), 32'd0);
    check_eq("t4_busy_kept", 32'(busy_b), 32'd1);
    check_eq("t4_viol", 32'(viol[1]), 32'd0);

    // Reset asserted while dut_a waits in WAIT_DONE.
    start_test();
    push(0, 3, 8'h31, 1'b0); push(0, 3, 8'h32, 1'b1);
    for (int i = 0; i < 100 && rdy_cnt[0][3] == 0; i++) tick();
    repeat (3) tick();
    push(0, 1, 8'h15, 1'b1);
    check_eq("t5_pre_grant", 32'(grant_a), 32'd3);
    check_eq("t5_pre_urdy", 32'(bus_a.uart_tx_rdy), 32'd0);
    reset = 1'b1;
    tick();
    check_eq("t5_tx_vld", 32'(bus_a.uart_tx_vld), 32'd0);
    check_eq("t5_req_rdy", 32'(bus_a.req_rdy), 32'd0);
    check_eq("t5_busy", 32'(busy_a), 32'd0);
    check_eq("t5_grant", 32'(grant_a), 32'd0);
    reset = 1'b0;
    clear_mon();
    for (int i = 0; i < 50 && n_ord[0] == 0; i++) tick();
    check_eq("t5_first_winner", 32'(ord[0][0]), 32'd1);

    // Stalled owner on dut_b (TIMEOUT_CLKS=20), req 1 waiting.
    start_test();
    push(1, 0, 8'hC1, 1'b0);
    push(1, 1, 8'hD1, 1'b1);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 200 && to_cnt[1] == 0; i++) tick();
    check_eq("t6_to_seen", 32'(to_cnt[1]), 32'd1);
    check_eq("t6_to_cycle", 32'(to_cyc[1] - rise_cyc[1]), 32'd20);
    repeat (3) tick();
    check_eq("t6_to_width", 32'(to_cnt[1]), 32'd1);
    for (int i = 0; i < 50 && n_ord[1] < 2; i++) tick();
    check_eq("t6_next_owner", 32'(ord[1][1]), 32'd1);
`else
    for (int i = 0; i < 100 && n_tx[1] == 0; i++) tick();
    repeat (60) tick();
    check_eq("t6_no_timeout", 32'(to_cnt[1]), 32'd0);
    check_eq("t6_grant_held", 32'(grant_b), 32'd0);
    check_eq("t6_busy_held", 32'(busy_b), 32'd1);
    check_eq("t6_n_ord", 32'(n_ord[1]), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
